// File: rtl/max_window_pkg.sv
// Shared types, default widths and window-length normalisation for max_window_hold.
package max_window_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_t;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefLenW  = 16;

  // A zero-length request degenerates to a single-sample window.
  function automatic logic [31:0] norm_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/max_window_hold.sv
// Windowed peak-hold: reduces each window of we-strobed samples to a peak value and its index.
// Optional MAX_WINDOW_IDX_EN builds the peak-index tracking; otherwise max_idx is tied to 0.
module max_window_hold
  import max_window_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             cont,
  input  logic [LEN_W-1:0] win_len,
  output logic [WIDTH-1:0] max_out,
  output logic [LEN_W-1:0] max_idx,
  output logic             valid,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q, len_norm;
  logic [WIDTH-1:0] cur_max_q, max_out_q, peak;
  logic             valid_q, sample, take, close, arm;

  assign len_norm = LEN_W'(norm_len(32'(win_len)));
  assign arm      = (state_q == StIdle) && start;
  assign sample   = (state_q == StRun) && we;
  // First sample of a window always loads; later ones only on a strict increase.
  assign take     = (cnt_q == '0) || (data_in > cur_max_q);
  assign close    = sample && (cnt_q == (len_q - LEN_W'(1)));
  assign peak     = take ? data_in : cur_max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (close && !cont) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      cur_max_q <= '0;
      max_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= close;
      if (arm) begin
        len_q     <= len_norm;
        cnt_q     <= '0;
        cur_max_q <= '0;
      end else if (sample) begin
        cur_max_q <= peak;
        if (close) begin
          max_out_q <= peak;
          cnt_q     <= '0;
          if (cont) len_q <= len_norm;
        end else begin
          cnt_q <= cnt_q + LEN_W'(1);
        end
      end
    end
  end

`ifdef MAX_WINDOW_IDX_EN
  logic [LEN_W-1:0] cur_idx_q, max_idx_q, idx_pick;

  assign idx_pick = take ? cnt_q : cur_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_idx_q <= '0;
      max_idx_q <= '0;
    end else if (arm) begin
      cur_idx_q <= '0;
    end else if (sample) begin
      cur_idx_q <= idx_pick;
      if (close) max_idx_q <= idx_pick;
    end
  end
`endif

  always_comb begin
    busy    = (state_q == StRun);
    valid   = valid_q;
    max_out = max_out_q;
`ifdef MAX_WINDOW_IDX_EN
    max_idx = max_idx_q;
`else
    max_idx = '0;
`endif
  end

endmodule

// File: tb/tb_max_window_hold.sv
// Self-checking bench for max_window_hold: directed scenarios plus random traffic against
// a window-buffer reference model.
module tb_max_window_hold;

  localparam int unsigned W = 16;
  localparam int unsigned L = 16;

  logic         clk = 1'b0;
  logic         rst, we, start, cont;
  logic [W-1:0] data_in;
  logic [L-1:0] win_len;
  logic [W-1:0] max_out;
  logic [L-1:0] max_idx;
  logic         valid, busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_busy = 1'b0;
  int unsigned m_len  = 1;
  int unsigned win[$];
  int unsigned exp_max = 0, exp_idx = 0;
  bit          exp_valid = 1'b0;

  max_window_hold #(.WIDTH(W), .LEN_W(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .data_in (data_in),
    .start   (start),
    .cont    (cont),
    .win_len (win_len),
    .max_out (max_out),
    .max_idx (max_idx),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Applies the current inputs to the model, as the clock edge will.
  task automatic model_edge();
    int unsigned best, bidx;
    exp_valid = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      win.delete();
      exp_max = 0;
      exp_idx = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_len  = (win_len == 0) ? 1 : int'(win_len);
        win.delete();
      end
    end else if (we) begin
      win.push_back(int'(data_in));
      if (win.size() == m_len) begin
        best = win[0];
        bidx = 0;
        for (int i = 1; i < win.size(); i++) begin
          if (win[i] > best) begin
            best = win[i];
            bidx = i;
          end
        end
        exp_max   = best;
`ifdef MAX_WINDOW_IDX_EN
        exp_idx   = bidx;
`else
        exp_idx   = 0;
`endif
        exp_valid = 1'b1;
        win.delete();
        if (cont) m_len = (win_len == 0) ? 1 : int'(win_len);
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit w, input int unsigned d,
                      input bit c, input int unsigned l);
    rst     = r;
    start   = s;
    we      = w;
    data_in = W'(d);
    cont    = c;
    win_len = L'(l);
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("max_out", 32'(max_out), exp_max);
    chk("max_idx", 32'(max_idx), exp_idx);
  endtask

  int unsigned idx_exp1;

  initial begin
`ifdef MAX_WINDOW_IDX_EN
    idx_exp1 = 1;
`else
    idx_exp1 = 0;
`endif
    // Reset state
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_max_out", 32'(max_out), 0);
    chk("rst_busy", 32'(busy), 0);

    // Window of 4 with a tie: 3,9,9,2
    tick(0, 1, 1, 77, 0, 4);  // we coincident with start is not counted
    chk("busy_after_start", 32'(busy), 1);
    tick(0, 0, 1, 3, 0, 0);
    tick(0, 0, 1, 9, 0, 0);
    tick(0, 0, 1, 9, 0, 0);
    chk("no_valid_early", 32'(valid), 0);
    tick(0, 0, 1, 2, 0, 0);
    chk("s1_valid", 32'(valid), 1);
    chk("s1_max", 32'(max_out), 9);
    chk("s1_idx", 32'(max_idx), idx_exp1);
    chk("s1_busy", 32'(busy), 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("s1_hold", 32'(max_out), 9);

    // win_len=0 means one sample
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 7, 0, 0);
    chk("s2_max", 32'(max_out), 7);
    chk("s2_idx", 32'(max_idx), 0);

    // Continuous, win_len=3, samples 1..9
    tick(0, 1, 0, 0, 1, 3);
    for (int i = 1; i <= 9; i++) begin
      tick(0, 0, 1, i, (i < 9), 3);
      if (i % 3 == 0) chk("s3_max", 32'(max_out), i);
    end
    chk("s3_idle", 32'(busy), 0);

    // Gaps ignored: 4,_,8,_,1,0,2
    tick(0, 1, 0, 0, 0, 5);
    tick(0, 0, 1, 4, 0, 0);
    tick(0, 0, 0, 50, 0, 0);
    tick(0, 0, 1, 8, 0, 0);
    tick(0, 0, 0, 60, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 2, 0, 0);
    chk("s4_max", 32'(max_out), 8);
    chk("s4_idx", 32'(max_idx), idx_exp1);

    // Reset aborts a partial window
    tick(0, 1, 0, 0, 0, 4);
    tick(0, 0, 1, 20, 0, 0);
    tick(0, 0, 1, 30, 0, 0);
    tick(1, 0, 1, 40, 0, 0);
    chk("s5_rst_max", 32'(max_out), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    tick(0, 0, 1, 50, 0, 0);
    chk("s5_no_valid", 32'(valid), 0);
    tick(0, 1, 0, 0, 0, 2);
    tick(0, 0, 1, 5, 0, 0);
    tick(0, 0, 1, 6, 0, 0);
    chk("s5_max", 32'(max_out), 6);
    chk("s5_idx", 32'(max_idx), idx_exp1);

    // Random traffic with small values to provoke ties
    for (int n = 0; n < 4000; n++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), $urandom_range(0, 15),
           ($urandom_range(0, 1) == 1), $urandom_range(0, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max_window_hold.md
# max_window_hold

Windowed peak-hold stage placed directly downstream of the parallel-maximum block. Each `we` strobe delivers that block's per-cycle maximum; this block reduces a programmable window of such samples to one peak value plus the in-window position of that peak. Results are emitted with a one-cycle `valid` pulse. It runs single-shot or back-to-back without dropping samples, feeding detection/threshold logic downstream.

## Interface
Parameters:
- `WIDTH`, 16, sample width. Must match the upstream max stage width. Unsigned.
- `LEN_W`, 16, width of the window length and index.

Ports:
- `clk`, in, 1, single clock for all logic.
- `rst`, in, 1, synchronous, active-high reset.
- `we`, in, 1, sample strobe. Same meaning as the upstream write enable.
- `data_in`, in, `WIDTH`, sample. Qualified by `we`.
- `start`, in, 1, arm a window. Sampled only in IDLE.
- `cont`, in, 1, continuous mode. Sampled when a window closes.
- `win_len`, in, `LEN_W`, samples per window. Latched on accepted `start` and on each continuous restart.
- `max_out`, out, `WIDTH`, peak of the last completed window.
- `max_idx`, out, `LEN_W`, index within the window (0-based) of the first occurrence of the peak.
- `valid`, out, 1, one-cycle pulse when `max_out`/`max_idx` are updated.
- `busy`, out, 1, high while in RUN.

## Operation
- States: IDLE, RUN.
- IDLE → RUN on `start`=1:
  - latch `win_len` to `len_q`; if `win_len`=0, use `len_q`=1;
  - clear `cnt`=0, `cur_max`=0, `cur_idx`=0.
- RUN, `we`=1:
  - if `cnt`=0 or `data_in` > `cur_max` (unsigned, strict), load `cur_max`=`data_in` and `cur_idx`=`cnt`;
  - `cnt` increments.
- Ties keep the earlier index. Samples with `we`=0 are ignored.
- Window close: `we`=1 with `cnt`=`len_q`-1.
  - `max_out`/`max_idx` register the final values, including the closing sample.
  - `valid` pulses.
  - If `cont`=1: stay in RUN, re-latch `win_len` (0→1), set `cnt`=0. The next `we` sample is index 0, so no sample is lost.
  - Otherwise go to IDLE.
- `start` while in RUN is ignored. `win_len` changes mid-window have no effect.
- `cnt` never wraps. It saturates by construction at `len_q`-1 ≤ 2^`LEN_W`-2, and `win_len` = all-ones gives the maximum window.
- `rst` at any time:
  - state → IDLE;
  - `cnt`, `cur_max`, `cur_idx` → 0;
  - `max_out`=0, `max_idx`=0, `valid`=0, `busy`=0.
  - Any partial window is discarded and no `valid` is issued for it.

## Timing
- `start` at cycle t → `busy`=1 from t+1. A `we` at t+1 is sample index 0. A `we` coincident with `start` is not counted.
- Closing `we` at cycle t → `valid`=1 at t+1, with `max_out`/`max_idx` valid at t+1. They hold until the next `valid`.
- Single-shot: `busy`=0 from t+1, the same cycle as `valid`.
- Continuous: `busy` stays 1. A `we` at t+1 starts the next window.
- Minimum window period with `we` every cycle is `len_q` cycles. Throughput is one sample per clock.
- Reset asserted at cycle t → all outputs at reset values from t+1.

## Configuration
- `MAX_WINDOW_IDX_EN` defined:
  - `cur_idx` and the `max_idx` register are built;
  - `max_idx` behaves as above.
- Not defined:
  - no index registers;
  - `max_idx` is tied to 0;
  - the peak value and all timing are unchanged.

## Structure
- Package `max_window_pkg`:
  - `state_t` enum {IDLE, RUN};
  - default `WIDTH`/`LEN_W` constants;
  - window-length normalisation function (0→1).
- Single module, no sub-module. The compare/update datapath is small and shares the counter with control.

## Test plan
- `win_len`=4, `start`, samples 3,9,9,2 on consecutive `we` → `valid` one cycle after the 4th sample; `max_out`=9, `max_idx`=1 (tie keeps first); `busy`=0 with `valid`.
- `win_len`=0, `start`, one sample 7 → window length 1; `valid` with `max_out`=7, `max_idx`=0.
- `cont`=1, `win_len`=3, `we` every cycle with 1..9 → three `valid` pulses spaced 3 cycles apart; `max_out`=3,6,9; `max_idx`=2 each; no sample lost.
- `win_len`=5, samples 4,_,8,_,1,0,2 with gaps (`we`=0 cycles) → gap cycles ignored; `max_out`=8, `max_idx`=1.
- Assert `rst` after 2 of 4 samples, then `start` with `win_len`=2, samples 5,6 → no `valid` for the aborted window; outputs 0 after reset; then `max_out`=6, `max_idx`=1.
- `MAX_WINDOW_IDX_EN` undefined, first scenario repeated → `max_out`=9, `max_idx`=0, same `valid` timing.
